// File: rtl/io_bus_controller.sv
// io_bus_controller: bridges single CPU IO requests onto eight device slots.
// Slots 0..3 (EIC, BKD, UART, STMR) are real devices; slots 4..7 are reserved
// and are answered immediately with an error and no device select.
// Optional feature: define IO_BUS_TIMEOUT_EN to abort an access that sees no
// DevReady for TIMEOUT_CYCLES cycles. Without it, an access waits forever.
module io_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         IoReq,
  input  logic         IoWe,
  input  logic [6:0]   IoAddr,
  input  logic [31:0]  IoWrData,
  output logic [31:0]  IoRdData,
  output logic         IoAck,
  output logic         IoErr,
  output logic [7:0]   DevSel,
  output logic [3:0]   DevRegAddr,
  output logic         DevWe,
  output logic [31:0]  DevWrData,
  input  logic [255:0] DevRdData,
  input  logic [7:0]   DevReady
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [2:0]  r_dev;
  logic [3:0]  r_regAddr;
  logic        r_we;
  logic [31:0] r_wrData;
  logic        r_err;
  logic [31:0] r_rdData;

  logic        w_inAccess;
  logic        w_devReady;
  logic [31:0] w_devRdData;
  logic        w_timeout;
  logic        w_reqReserved;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("io_bus_controller: TIMEOUT_CYCLES must be within 2..255");
  end

  assign w_inAccess    = (r_state == ACCESS);
  assign w_reqReserved = IoAddr[6];
  assign w_devReady    = DevReady[r_dev];
  assign w_devRdData   = DevRdData[{r_dev, 5'd0} +: 32];

`ifdef IO_BUS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  // Count ACCESS cycles without DevReady; cleared whenever we are not in ACCESS
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (r_state != ACCESS) begin
      r_count <= '0;
    end else if (!w_devReady) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign w_timeout = w_inAccess && !w_devReady && (r_count == TimeoutLast);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; DevReady wins over a timeout landing in the same cycle
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (IoReq) begin
          w_nextState = w_reqReserved ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (w_devReady || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the request on acceptance and record the outcome of the access
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dev     <= '0;
      r_regAddr <= '0;
      r_we      <= 1'b0;
      r_wrData  <= '0;
      r_err     <= 1'b0;
      r_rdData  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IoReq) begin
            r_dev     <= IoAddr[6:4];
            r_regAddr <= IoAddr[3:0];
            r_we      <= IoWe;
            r_wrData  <= IoWrData;
            r_err     <= w_reqReserved;
            if (w_reqReserved && !IoWe) begin
              r_rdData <= '0;
            end
          end
        end
        ACCESS: begin
          if (w_devReady) begin
            r_err <= 1'b0;
            if (!r_we) begin
              r_rdData <= w_devRdData;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we) begin
              r_rdData <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign DevSel     = w_inAccess ? (8'd1 << r_dev) : 8'd0;
  assign DevWe      = w_inAccess & r_we;
  assign DevRegAddr = r_regAddr;
  assign DevWrData  = r_wrData;
  assign IoAck      = (r_state == RESP);
  assign IoErr      = (r_state == RESP) & r_err;
  assign IoRdData   = r_rdData;

endmodule

// File: tb/tb_io_bus_controller.sv
// tb_io_bus_controller: directed transactions against io_bus_controller.
// Expected outputs come from a transaction-level model of the bus rules and
// are compared on every falling clock edge; literal values pin the model.
// Build with or without IO_BUS_TIMEOUT_EN; the model follows the same macro.
module tb_io_bus_controller;

  localparam int unsigned To = 16;

`ifdef IO_BUS_TIMEOUT_EN
  localparam bit ToEnabled = 1'b1;
`else
  localparam bit ToEnabled = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         IoReq = 1'b0;
  logic         IoWe = 1'b0;
  logic [6:0]   IoAddr = '0;
  logic [31:0]  IoWrData = '0;
  logic [31:0]  IoRdData;
  logic         IoAck;
  logic         IoErr;
  logic [7:0]   DevSel;
  logic [3:0]   DevRegAddr;
  logic         DevWe;
  logic [31:0]  DevWrData;
  logic [255:0] DevRdData = '0;
  logic [7:0]   DevReady = '0;

  io_bus_controller #(.TIMEOUT_CYCLES(To)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .IoReq      (IoReq),
    .IoWe       (IoWe),
    .IoAddr     (IoAddr),
    .IoWrData   (IoWrData),
    .IoRdData   (IoRdData),
    .IoAck      (IoAck),
    .IoErr      (IoErr),
    .DevSel     (DevSel),
    .DevRegAddr (DevRegAddr),
    .DevWe      (DevWe),
    .DevWrData  (DevWrData),
    .DevRdData  (DevRdData),
    .DevReady   (DevReady)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 Clock = ~Clock;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0]  expSel = '0;
  logic        expWe = 1'b0;
  logic [3:0]  expRegAddr = '0;
  logic [31:0] expWrData = '0;
  logic        expAck = 1'b0;
  logic        expErr = 1'b0;
  logic [31:0] expRd = '0;
  logic        chkEn = 1'b0;

  int totalCyc = 0;
  int totalSel = 0;
  int lastAckCyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0h required %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge Clock) begin
    if (chkEn) begin
      checkOutput("DevSel", 32'(DevSel), 32'(expSel));
      checkOutput("DevWe", 32'(DevWe), 32'(expWe));
      if (expSel != 8'd0) begin
        checkOutput("DevRegAddr", 32'(DevRegAddr), 32'(expRegAddr));
        checkOutput("DevWrData", DevWrData, expWrData);
      end
      checkOutput("IoAck", 32'(IoAck), 32'(expAck));
      if (expAck) begin
        checkOutput("IoErr", 32'(IoErr), 32'(expErr));
      end
      checkOutput("IoRdData", IoRdData, expRd);
    end
  end

  // Cycle monitor used for the literal latency and select-length checks
  always @(negedge Clock) begin
    totalCyc = totalCyc + 1;
    if (DevSel != 8'd0) totalSel = totalSel + 1;
    if (IoAck) lastAckCyc = totalCyc;
  end

  task automatic setIdleExp();
    expSel = '0;
    expWe  = 1'b0;
    expAck = 1'b0;
    expErr = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // Pulse reset in the middle of a cycle and check outputs clear at once
  task automatic pulseReset();
    Reset_n  = 1'b0;
    IoReq    = 1'b0;
    DevReady = '0;
    #1;
    checkOutput("rstIoAck", 32'(IoAck), 32'd0);
    checkOutput("rstIoErr", 32'(IoErr), 32'd0);
    checkOutput("rstDevSel", 32'(DevSel), 32'd0);
    checkOutput("rstDevWe", 32'(DevWe), 32'd0);
    checkOutput("rstIoRdData", IoRdData, 32'd0);
    checkOutput("rstDevRegAddr", 32'(DevRegAddr), 32'd0);
    checkOutput("rstDevWrData", DevWrData, 32'd0);
    setIdleExp();
    expRd = '0;
    #2;
    Reset_n = 1'b1;
  endtask

  // One CPU transaction. readyAt: ACCESS cycle (1-based) in which the target
  // raises DevReady, 0 = never. abortAt: ACCESS cycle in which reset is
  // pulsed, 0 = none. Called at 1 ns after a rising edge in an idle cycle.
  task automatic applyStimulus(input logic [6:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [31:0] devData,
                               input int readyAt, input int abortAt,
                               output int ackLat, output int selCyc);
    logic [2:0]  dev;
    logic [7:0]  devBit;
    bit          reserved;
    bit          err;
    bit          aborted;
    int          accessCycles;
    int          startCyc;
    int          startSel;
    logic [31:0] newRd;

    dev      = addr[6:4];
    devBit   = 8'd1 << dev;
    reserved = (dev >= 3'd4);
    aborted  = 1'b0;

    // Outcome from the bus rules
    if (reserved) begin
      accessCycles = 0;
      err = 1'b1;
    end else if (readyAt != 0 && (!ToEnabled || readyAt <= int'(To))) begin
      accessCycles = readyAt;
      err = 1'b0;
    end else if (ToEnabled) begin
      accessCycles = int'(To);
      err = 1'b1;
    end else begin
      accessCycles = abortAt;
      err = 1'b0;
    end
    newRd = we ? expRd : (err ? 32'd0 : devData);

    // Request cycle
    IoReq    = 1'b1;
    IoAddr   = addr;
    IoWe     = we;
    IoWrData = wdata;
    DevReady = 8'hFF;
    for (int d = 0; d < 8; d++) begin
      DevRdData[d*32 +: 32] = (d == int'(dev)) ? devData : (32'hE000_0000 | 32'(d));
    end
    setIdleExp();
    nextCycle();

    // Accepted: later input changes must not leak into the transaction
    startCyc = totalCyc;
    startSel = totalSel;
    IoAddr   = ~addr;
    IoWe     = ~we;
    IoWrData = ~wdata;

    for (int k = 1; k <= accessCycles; k++) begin
      if (abortAt != 0 && k == abortAt) begin
        pulseReset();
        aborted = 1'b1;
        break;
      end
      expSel     = devBit;
      expWe      = we;
      expRegAddr = addr[3:0];
      expWrData  = wdata;
      expAck     = 1'b0;
      DevReady   = ~devBit | ((k == readyAt) ? devBit : 8'd0);
      nextCycle();
    end

    if (!aborted) begin
      DevReady  = '0;
      DevRdData = {8{32'h5A5A_5A5A}};
      expSel    = '0;
      expWe     = 1'b0;
      expAck    = 1'b1;
      expErr    = err;
      expRd     = newRd;
      nextCycle();
      IoReq = 1'b0;
      setIdleExp();
    end else begin
      repeat (3) nextCycle();
    end

    ackLat = (lastAckCyc > startCyc) ? (lastAckCyc - startCyc) : 0;
    selCyc = totalSel - startSel;
  endtask

  int lat;
  int sel;

  initial begin
    nextCycle();
    chkEn = 1'b1;
    pulseReset();
    nextCycle();

    // Read from STMR, ready immediately
    applyStimulus(7'h31, 1'b0, 32'h0, 32'h0000_1234, 1, 0, lat, sel);
    checkOutput("rdStmrLatency", 32'(lat), 32'd2);
    checkOutput("rdStmrSelCycles", 32'(sel), 32'd1);
    checkOutput("rdStmrData", IoRdData, 32'h0000_1234);

    // Back-to-back write to UART, ready on 3rd ACCESS cycle
    applyStimulus(7'h24, 1'b1, 32'h0000_0055, 32'hFFFF_0000, 3, 0, lat, sel);
    checkOutput("wrUartLatency", 32'(lat), 32'd4);
    checkOutput("wrUartSelCycles", 32'(sel), 32'd3);
    checkOutput("wrUartRdKept", IoRdData, 32'h0000_1234);

    // Reserved device read
    applyStimulus(7'h50, 1'b0, 32'h0, 32'hDDDD_DDDD, 1, 0, lat, sel);
    checkOutput("rdRsvLatency", 32'(lat), 32'd1);
    checkOutput("rdRsvSelCycles", 32'(sel), 32'd0);
    checkOutput("rdRsvData", IoRdData, 32'd0);

    repeat (2) nextCycle();
    applyStimulus(7'h02, 1'b0, 32'h0, 32'hA5A5_0001, 2, 0, lat, sel);
    checkOutput("rdEicData", IoRdData, 32'hA5A5_0001);

    // Reserved write leaves read data alone
    applyStimulus(7'h7F, 1'b1, 32'h1111_2222, 32'h0, 1, 0, lat, sel);
    checkOutput("wrRsvRdKept", IoRdData, 32'hA5A5_0001);

    applyStimulus(7'h1C, 1'b0, 32'h0, 32'hDEAD_BEEF, 5, 0, lat, sel);
    checkOutput("rdBkdLatency", 32'(lat), 32'd6);

    // Ready in the last permitted cycle completes successfully
    applyStimulus(7'h2A, 1'b0, 32'h0, 32'hCAFE_0016, 16, 0, lat, sel);
    checkOutput("rdEdgeLatency", 32'(lat), 32'd17);
    checkOutput("rdEdgeData", IoRdData, 32'hCAFE_0016);

    // Ready one cycle past the limit
    applyStimulus(7'h3B, 1'b0, 32'h0, 32'h0BAD_0017, 17, 0, lat, sel);
`ifdef IO_BUS_TIMEOUT_EN
    checkOutput("rdLateLatency", 32'(lat), 32'd17);
    checkOutput("rdLateData", IoRdData, 32'd0);
`else
    checkOutput("rdLateLatency", 32'(lat), 32'd18);
    checkOutput("rdLateData", IoRdData, 32'h0BAD_0017);
`endif

    // No DevReady at all
    applyStimulus(7'h00, 1'b0, 32'h0, 32'h7777_7777, 0, 1001, lat, sel);
`ifdef IO_BUS_TIMEOUT_EN
    checkOutput("rdDeadSelCycles", 32'(sel), 32'd16);
    checkOutput("rdDeadLatency", 32'(lat), 32'd17);
`else
    checkOutput("rdDeadSelCycles", 32'(sel), 32'd1000);
    checkOutput("rdDeadLatency", 32'(lat), 32'd0);
`endif
    checkOutput("rdDeadData", IoRdData, 32'd0);

    // Reset in the 2nd ACCESS cycle, then the same read again
    applyStimulus(7'h13, 1'b0, 32'h0, 32'h1313_0013, 0, 2, lat, sel);
    checkOutput("rstMidLatency", 32'(lat), 32'd0);
    checkOutput("rstMidSelCycles", 32'(sel), 32'd1);
    applyStimulus(7'h13, 1'b0, 32'h0, 32'h1313_0013, 1, 0, lat, sel);
    checkOutput("rdAfterRstLatency", 32'(lat), 32'd2);
    checkOutput("rdAfterRstData", IoRdData, 32'h1313_0013);

    repeat (2) nextCycle();
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/io_bus_controller.md
IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles in ACCESS without DevReady before timeout error; legal 2..255.
REQ-002 SHALL have port Clock  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port Reset_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port IoReq  in  1  CPU IO request; held high until IoAck.
REQ-005 SHALL have port IoWe  in  1  1=write, 0=read; stable while IoReq high.
REQ-006 SHALL have port IoAddr  in  7  [6:4] device index, [3:0] register index.
REQ-007 SHALL have port IoWrData  in  32  CPU write data.
REQ-008 SHALL have port IoRdData  out  32  read data; valid with IoAck.
REQ-009 SHALL have port IoAck  out  1  one-cycle completion pulse.
REQ-010 SHALL have port IoErr  out  1  error flag; qualified by IoAck.
REQ-011 SHALL have port DevSel  out  8  one-hot device select.
REQ-012 SHALL have port DevRegAddr  out  4  register index to devices.
REQ-013 SHALL have port DevWe  out  1  write strobe, qualified by DevSel.
REQ-014 SHALL have port DevWrData  out  32  write data to devices.
REQ-015 SHALL have port DevRdData  in  256  eight 32-bit read buses; device n at [32n+31:32n].
REQ-016 SHALL have port DevReady  in  8  per-device access-complete, one bit per device.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE: IoReq=1 sampled -> latch IoAddr, IoWe, IoWrData; device 0..3 (EIC, BKD, UART, STMR) -> ACCESS; device 4..7 (reserved) -> RESP with error, no DevSel.
REQ-019 ACCESS: DevSel[dev]=1, DevRegAddr/DevWe/DevWrData driven from latched values, held stable every ACCESS cycle.
REQ-020 ACCESS: DevReady[dev]=1 -> write done, or read captures DevRdData[dev]; next state RESP, no error; DevReady bits of other devices ignored.
REQ-021 RESP: IoAck=1 one cycle, IoErr per transaction, DevSel=0; next IDLE unconditionally.
REQ-022 Latency: DevReady high on first ACCESS cycle -> IoAck 2 cycles after request sampled; reserved device -> IoAck 1 cycle after.
REQ-023 Requester SHALL drop IoReq at edge after IoAck; IoReq high in IDLE = new request (back-to-back, one idle cycle min).
REQ-024 IoRdData: registered; updated only on read completion: device data on success, 32'h0 on errored read; unchanged by writes.
REQ-025 DevWe SHALL be 0 whenever DevSel is 0; DevSel at most one bit set.
REQ-026 IoAddr/IoWe/IoWrData changes after acceptance SHALL NOT affect the in-flight transaction.

Reset
REQ-027 Reset_n low SHALL force IDLE asynchronously; IoAck, IoErr, DevSel, DevWe = 0; IoRdData, DevRegAddr, DevWrData = 0; timeout counter = 0.
REQ-028 Reset mid-transaction SHALL abandon it with no IoAck; first request after deassertion is accepted normally.

Configuration
REQ-029 Macro IO_BUS_TIMEOUT_EN defined: counter zeroed on ACCESS entry, increments per ACCESS cycle without DevReady; reaching TIMEOUT_CYCLES -> RESP with IoErr=1, DevSel dropped, read data 0.
REQ-030 DevReady in the same cycle the count reaches TIMEOUT_CYCLES SHALL win (success).
REQ-031 Macro undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES ignored.

Verification
REQ-032 Read IoAddr=7'h31, DevReady[3] high immediately, DevRdData[3]=32'h0000_1234 -> DevSel=8'h08 for 1 cycle, DevRegAddr=4'h1, IoAck 2 cycles after request, IoRdData=32'h0000_1234, IoErr=0.
REQ-033 Write IoAddr=7'h24, IoWrData=32'h0000_0055, DevReady[2] after 3 ACCESS cycles -> DevSel=8'h04, DevWe=1, DevWrData=32'h55 for 3 cycles, then IoAck, IoErr=0, IoRdData unchanged.
REQ-034 Read IoAddr=7'h50 -> no DevSel, IoAck 1 cycle after request, IoErr=1, IoRdData=0.
REQ-035 With IO_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, read IoAddr=7'h00, DevReady held 0 -> DevSel=8'h01 for 16 cycles, IoAck with IoErr=1, IoRdData=0; macro undefined -> no IoAck after 1000 cycles.
REQ-036 Reset_n pulsed low on 2nd ACCESS cycle of read 7'h13 -> outputs 0 immediately, no IoAck; subsequent read 7'h13 completes normally.
